// File: rtl/mips_control_if.sv
// Decode bus between instruction decode and the main control unit:
// opcode/function field in, datapath steering signals out.
interface mips_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       reg_dest;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [3:0] alu_ctrl;

    // Instruction source: drives op/funct, consumes control outputs
    modport master (
        output op,
        output funct,
        input  reg_dest,
        input  branch,
        input  mem_read,
        input  mem_to_reg,
        input  mem_write,
        input  alu_src,
        input  reg_write,
        input  alu_ctrl
    );

    // Control unit: consumes op/funct, drives control outputs
    modport slave (
        input  op,
        input  funct,
        output reg_dest,
        output branch,
        output mem_read,
        output mem_to_reg,
        output mem_write,
        output alu_src,
        output reg_write,
        output alu_ctrl
    );
endinterface

// File: rtl/mips_control.sv
// Main decode/control unit for the single-cycle MIPS datapath.
// Decodes op/funct combinationally and registers every control output,
// so the datapath sees the decode of the instruction sampled one edge earlier.
// Unsupported opcodes and unsupported R-type functions decode to all zeros.
module mips_control (
    input  logic          clk,
    input  logic          rst,
    mips_control_if.slave ctrl
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_NOR   = 6'b100111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // Maps an R-type function field to {supported, alu code}
    function automatic logic [4:0] rtype_alu(input logic [5:0] funct);
        logic [4:0] res;
        case (funct)
            FN_ADD:  res = {1'b1, ALU_ADD};
            FN_SUB:  res = {1'b1, ALU_SUB};
            FN_AND:  res = {1'b1, ALU_AND};
            FN_OR:   res = {1'b1, ALU_OR};
            FN_SLT:  res = {1'b1, ALU_SLT};
            FN_NOR:  res = {1'b1, ALU_NOR};
            default: res = {1'b0, ALU_AND};
        endcase
        return res;
    endfunction

    logic       reg_dest_s;
    logic       branch_s;
    logic       mem_read_s;
    logic       mem_to_reg_s;
    logic       mem_write_s;
    logic       alu_src_s;
    logic       reg_write_s;
    logic [3:0] alu_ctrl_s;
    logic       funct_ok_s;
    logic [3:0] funct_alu_s;

    logic       reg_dest_r;
    logic       branch_r;
    logic       mem_read_r;
    logic       mem_to_reg_r;
    logic       mem_write_r;
    logic       alu_src_r;
    logic       reg_write_r;
    logic [3:0] alu_ctrl_r;

    // Combinational decode of the current op/funct into next control values
    always_comb begin
        reg_dest_s   = 1'b0;
        branch_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_to_reg_s = 1'b0;
        mem_write_s  = 1'b0;
        alu_src_s    = 1'b0;
        reg_write_s  = 1'b0;
        alu_ctrl_s   = ALU_AND;
        {funct_ok_s, funct_alu_s} = rtype_alu(ctrl.funct);
        case (ctrl.op)
            OP_RTYPE: begin
                if (funct_ok_s) begin
                    reg_dest_s  = 1'b1;
                    reg_write_s = 1'b1;
                    alu_ctrl_s  = funct_alu_s;
                end else begin
                    // unknown function: behave as a NOP
                    alu_ctrl_s  = ALU_AND;
                end
            end
            OP_LW: begin
                mem_read_s   = 1'b1;
                mem_to_reg_s = 1'b1;
                alu_src_s    = 1'b1;
                reg_write_s  = 1'b1;
                alu_ctrl_s   = ALU_ADD;
            end
            OP_SW: begin
                mem_write_s  = 1'b1;
                alu_src_s    = 1'b1;
                alu_ctrl_s   = ALU_ADD;
            end
            OP_BEQ: begin
                branch_s     = 1'b1;
                alu_ctrl_s   = ALU_SUB;
            end
            OP_ADDI: begin
                alu_src_s    = 1'b1;
                reg_write_s  = 1'b1;
                alu_ctrl_s   = ALU_ADD;
            end
            OP_ANDI: begin
                alu_src_s    = 1'b1;
                reg_write_s  = 1'b1;
                alu_ctrl_s   = ALU_AND;
            end
            OP_ORI: begin
                alu_src_s    = 1'b1;
                reg_write_s  = 1'b1;
                alu_ctrl_s   = ALU_OR;
            end
            OP_SLTI: begin
                alu_src_s    = 1'b1;
                reg_write_s  = 1'b1;
                alu_ctrl_s   = ALU_SLT;
            end
            default: begin
                alu_ctrl_s   = ALU_AND;
            end
        endcase
    end

    // Output registers: reset clears everything, otherwise capture the decode
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_dest_r   <= 1'b0;
            branch_r     <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_to_reg_r <= 1'b0;
            mem_write_r  <= 1'b0;
            alu_src_r    <= 1'b0;
            reg_write_r  <= 1'b0;
            alu_ctrl_r   <= 4'b0000;
        end else begin
            reg_dest_r   <= reg_dest_s;
            branch_r     <= branch_s;
            mem_read_r   <= mem_read_s;
            mem_to_reg_r <= mem_to_reg_s;
            mem_write_r  <= mem_write_s;
            alu_src_r    <= alu_src_s;
            reg_write_r  <= reg_write_s;
            alu_ctrl_r   <= alu_ctrl_s;
        end
    end

    assign ctrl.reg_dest   = reg_dest_r;
    assign ctrl.branch     = branch_r;
    assign ctrl.mem_read   = mem_read_r;
    assign ctrl.mem_to_reg = mem_to_reg_r;
    assign ctrl.mem_write  = mem_write_r;
    assign ctrl.alu_src    = alu_src_r;
    assign ctrl.reg_write  = reg_write_r;
    assign ctrl.alu_ctrl   = alu_ctrl_r;

endmodule

// File: tb/tb_mips_control.sv
// Testbench for mips_control: directed vector table, hand-written reset and
// mid-cycle sequences, and randomized stimulus against a table-lookup model.
// Output vector layout: {reg_dest, branch, mem_read, mem_to_reg, mem_write,
//                        alu_src, reg_write, alu_ctrl[3:0]}
module tb_mips_control;

    logic clk;
    logic rst;
    mips_control_if bus ();

    mips_control dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] act;
    assign act = {bus.reg_dest, bus.branch, bus.mem_read, bus.mem_to_reg,
                  bus.mem_write, bus.alu_src, bus.reg_write, bus.alu_ctrl};

    // Reference tables taken straight from the instruction list
    logic [5:0] op_key   [8];
    logic [6:0] op_flags [8];
    logic [3:0] op_alu   [8];
    logic [5:0] fn_key   [6];
    logic [3:0] fn_alu   [6];

    function automatic logic [10:0] ref_model(input logic [5:0] op, input logic [5:0] funct);
        logic [10:0] res;
        res = 11'd0;
        if (op == 6'd0) begin
            for (int i = 0; i < 6; i++)
                if (fn_key[i] == funct) res = {7'b1000001, fn_alu[i]};
        end else begin
            for (int i = 0; i < 8; i++)
                if (op_key[i] == op) res = {op_flags[i], op_alu[i]};
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, return at next falling edge
    task automatic apply(input logic r, input logic [5:0] o, input logic [5:0] f);
        rst = r;
        bus.op = o;
        bus.funct = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string n, input logic [5:0] o, input logic [5:0] f,
                                input logic [10:0] e);
        vec_t v;
        v.name = n; v.op = o; v.funct = f; v.exp = e;
        return v;
    endfunction

    initial begin
        logic [5:0]  r_op;
        logic [5:0]  r_fn;
        logic        r_rst;
        logic [10:0] e;
        logic [5:0]  ops_pool [10];

        op_key   = '{6'b100011, 6'b101011, 6'b000100, 6'b001000,
                     6'b001100, 6'b001101, 6'b001010, 6'b111110};
        op_flags = '{7'b0011011, 7'b0000110, 7'b0100000, 7'b0000011,
                     7'b0000011, 7'b0000011, 7'b0000011, 7'b0000000};
        op_alu   = '{4'b0010, 4'b0010, 4'b0110, 4'b0010,
                     4'b0000, 4'b0001, 4'b0111, 4'b0000};
        fn_key   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        fn_alu   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
        ops_pool = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
                     6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000101};

        rst = 1'b1;
        bus.op = 6'b100011;
        bus.funct = 6'b000000;

        // 1: reset with lw present, then release
        apply(1'b1, 6'b100011, 6'b000000);
        check("reset_c1", 11'd0);
        apply(1'b1, 6'b100011, 6'b000000);
        check("reset_c2", 11'd0);
        apply(1'b0, 6'b100011, 6'b000000);
        check("lw_after_reset", 11'b0011011_0010);

        // 2-5: directed vector table
        tbl.push_back(mk("r_add",  6'b000000, 6'b100000, 11'b1000001_0010));
        tbl.push_back(mk("r_sub",  6'b000000, 6'b100010, 11'b1000001_0110));
        tbl.push_back(mk("r_and",  6'b000000, 6'b100100, 11'b1000001_0000));
        tbl.push_back(mk("r_or",   6'b000000, 6'b100101, 11'b1000001_0001));
        tbl.push_back(mk("r_slt",  6'b000000, 6'b101010, 11'b1000001_0111));
        tbl.push_back(mk("r_nor",  6'b000000, 6'b100111, 11'b1000001_1100));
        tbl.push_back(mk("r_bad",  6'b000000, 6'b000000, 11'b0000000_0000));
        tbl.push_back(mk("sw",     6'b101011, 6'b100000, 11'b0000110_0010));
        tbl.push_back(mk("beq",    6'b000100, 6'b100111, 11'b0100000_0110));
        tbl.push_back(mk("addi",   6'b001000, 6'b000000, 11'b0000011_0010));
        tbl.push_back(mk("andi",   6'b001100, 6'b000000, 11'b0000011_0000));
        tbl.push_back(mk("ori",    6'b001101, 6'b000000, 11'b0000011_0001));
        tbl.push_back(mk("slti",   6'b001010, 6'b000000, 11'b0000011_0111));
        tbl.push_back(mk("op_3f",  6'b111111, 6'b100000, 11'b0000000_0000));
        tbl.push_back(mk("op_05",  6'b000101, 6'b100010, 11'b0000000_0000));
        tbl.push_back(mk("lw_fn",  6'b100011, 6'b101010, 11'b0011011_0010));
        foreach (tbl[i]) begin
            apply(1'b0, tbl[i].op, tbl[i].funct);
            check(tbl[i].name, tbl[i].exp);
        end

        // 5: funct changes under a non-zero op never move the outputs
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 6'b001101, fn_key[i]);
            check("ori_funct_ignored", 11'b0000011_0001);
        end

        // 6: mid-cycle changes only take effect at edges; reset edge yields zeros
        apply(1'b0, 6'b101011, 6'b000000);
        check("sw_before_mid", 11'b0000110_0010);
        #2 bus.op = 6'b001000;
        bus.funct = 6'b100111;
        #1 check("sw_hold_mid", 11'b0000110_0010);
        apply(1'b0, 6'b000000, 6'b100111);
        check("nor_after_edge", 11'b1000001_1100);
        #2 bus.op = 6'b000100;
        #1 check("nor_hold_mid", 11'b1000001_1100);
        apply(1'b1, 6'b100011, 6'b000000);
        check("reset_mid_stream", 11'd0);
        apply(1'b0, 6'b000100, 6'b000000);
        check("beq_not_lw_after_reset", 11'b0100000_0110);

        // Randomized stimulus against the table model
        for (int i = 0; i < 400; i++) begin
            r_op  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops_pool[$urandom_range(0, 9)];
            r_fn  = ($urandom_range(0, 1) == 0) ? fn_key[$urandom_range(0, 5)] : 6'($urandom);
            r_rst = ($urandom_range(0, 15) == 0);
            e = r_rst ? 11'd0 : ref_model(r_op, r_fn);
            apply(r_rst, r_op, r_fn);
            check("random", e);
            n_checks++;
            if ((bus.mem_read && bus.mem_write) ||
                (bus.reg_write && (bus.mem_write || bus.branch))) begin
                n_errors++;
                $display("FAIL invariant: got %b required no conflicting enables", act);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
